// File: rtl/s3_maxpool_buffer.sv
// s3_maxpool_buffer: stage-3 frame buffer plus 2x2/stride-2 max pooling.
// Collects NCH x IDIM x IDIM signed samples, then streams NCH x ODIM x ODIM
// pooled maxima in channel-major, row-major order.
// Optional build macro S3_OUT_SAT17_EN: saturate pooled outputs to the
// signed 17-bit range (sign-extended to DWIDTH).
//
// Handshake (both ports): a transfer happens on a rising edge where valid
// and ready are both high; once out_valid rises, out_ch/out_idx/out_data
// hold until a transfer, and out_valid never falls without a transfer.
module s3_maxpool_buffer #(
  parameter int DWIDTH = 35,
  parameter int NCH    = 4,
  parameter int IDIM   = 6,
  parameter int ODIM   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_ch,
  input  logic [5:0]               in_idx,
  input  logic signed [DWIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_ch,
  output logic [3:0]               out_idx,
  output logic signed [DWIDTH-1:0] out_data,
  output logic                     frame_done,
  output logic                     idx_err
);

  localparam int NPOS = IDIM * IDIM;
  localparam int NBUF = NCH * NPOS;
  localparam int AW   = $clog2(NBUF);
  localparam int CNTW = $clog2(NBUF + 1);
  localparam int RW   = $clog2(ODIM);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_POOL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic signed [DWIDTH-1:0] mem [0:NBUF-1];
  logic [NBUF-1:0]          bitmap;
  logic [CNTW-1:0]          cnt;

  // pooling iterator: points at the next window to load into the output register
  logic [1:0]    p_ch;
  logic [RW-1:0] p_row;
  logic [RW-1:0] p_col;

  logic                     out_valid_q;
  logic [1:0]               out_ch_q;
  logic [3:0]               out_idx_q;
  logic signed [DWIDTH-1:0] out_data_q;
  logic                     idx_err_q;

  logic                     idx_ok;
  logic                     wr_ok;
  logic                     wr_new;
  logic [AW-1:0]            wr_addr;
  logic [AW-1:0]            rd_base;
  logic signed [DWIDTH-1:0] rd0, rd1, rd2, rd3;
  logic signed [DWIDTH-1:0] pool_max;
  logic signed [DWIDTH-1:0] pool_out;
  logic                     xfer;
  logic                     last_out;

  assign idx_ok  = (in_idx < 6'(NPOS));
  assign wr_ok   = (state == S_FILL) && in_valid && idx_ok;
  assign wr_addr = AW'(in_ch) * AW'(NPOS) + AW'(in_idx);
  assign wr_new  = wr_ok && !bitmap[wr_addr];

  assign rd_base = AW'(p_ch) * AW'(NPOS) + AW'(p_row) * AW'(2 * IDIM) + AW'(p_col) * AW'(2);
  assign rd0 = mem[rd_base];
  assign rd1 = mem[rd_base + AW'(1)];
  assign rd2 = mem[rd_base + AW'(IDIM)];
  assign rd3 = mem[rd_base + AW'(IDIM + 1)];

  assign xfer     = out_valid_q && out_ready;
  assign last_out = (out_ch_q == 2'(NCH - 1)) && (out_idx_q == 4'(ODIM * ODIM - 1));

  // signed maximum of the 2x2 window; a tie keeps the earlier value
  always_comb begin
    pool_max = rd0;
    if (rd1 > pool_max) pool_max = rd1;
    if (rd2 > pool_max) pool_max = rd2;
    if (rd3 > pool_max) pool_max = rd3;
  end

`ifdef S3_OUT_SAT17_EN
  localparam logic signed [DWIDTH-1:0] SAT_HI = DWIDTH'(65535);
  localparam logic signed [DWIDTH-1:0] SAT_LO = DWIDTH'(-65536);

  // clamp the pooled maximum to the 17-bit signed range of the next stage
  always_comb begin
    pool_out = pool_max;
    if (pool_max > SAT_HI)      pool_out = SAT_HI;
    else if (pool_max < SAT_LO) pool_out = SAT_LO;
  end
`else
  // full-width pooled maximum passes through unchanged
  always_comb begin
    pool_out = pool_max;
  end
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_nx;
  end

  // next-state and state-decoded outputs
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (wr_new && (cnt == CNTW'(NBUF - 1))) state_nx = S_POOL;
      end
      S_POOL: begin
        if (xfer && last_out) state_nx = S_DONE;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nx   = S_FILL;
      end
      default: state_nx = S_FILL;
    endcase
  end

  // sample storage; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= in_data;
  end

  // bitmap, counter, error flag, pooling iterator and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bitmap      <= '0;
      cnt         <= '0;
      idx_err_q   <= 1'b0;
      p_ch        <= '0;
      p_row       <= '0;
      p_col       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_valid && !idx_ok) idx_err_q <= 1'b1;
          if (wr_ok) bitmap[wr_addr] <= 1'b1;
          if (wr_new) cnt <= cnt + CNTW'(1);
        end
        S_POOL: begin
          if (xfer && last_out) begin
            out_valid_q <= 1'b0;
          end else if (!out_valid_q || xfer) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= p_ch;
            out_idx_q   <= 4'(p_row) * 4'(ODIM) + 4'(p_col);
            out_data_q  <= pool_out;
            if (p_col == RW'(ODIM - 1)) begin
              p_col <= '0;
              if (p_row == RW'(ODIM - 1)) begin
                p_row <= '0;
                p_ch  <= p_ch + 2'd1;
              end else begin
                p_row <= p_row + RW'(1);
              end
            end else begin
              p_col <= p_col + RW'(1);
            end
          end
        end
        S_DONE: begin
          bitmap <= '0;
          cnt    <= '0;
          p_ch   <= '0;
          p_row  <= '0;
          p_col  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign idx_err   = idx_err_q;

endmodule

// File: doc/s3_maxpool_buffer.md
Name: s3_maxpool_buffer

Overview:
- Stage 3 of the convolution pipeline, directly downstream of the stage-2 tensor processor.
- Collects the 144 post-ReLU convolution results (4 filters x 6x6 positions, 35-bit signed) into an internal buffer.
- Once the buffer is complete, performs 2x2/stride-2 max pooling per filter and streams out 36 pooled values (4 x 3x3) over a valid/ready interface.

Parameters:
- DWIDTH, 35, data width of input and output samples (signed).
- NCH, 4, number of filter channels.
- IDIM, 6, input map side length; must be even.
- ODIM, 3, output map side length; equals IDIM/2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data, in_ch and in_idx are valid this cycle.
- in_ready  output  1  block accepts writes (high only in FILL).
- in_ch  input  2  filter channel of the sample.
- in_idx  input  6  position, row*IDIM+col, legal range 0..35.
- in_data  input  DWIDTH  signed convolution result.
- out_valid  output  1  out_data, out_ch and out_idx are valid.
- out_ready  input  1  downstream accepts the output.
- out_ch  output  2  channel of the pooled value.
- out_idx  output  4  pooled position, row*ODIM+col, range 0..8.
- out_data  output  DWIDTH  signed pooled maximum.
- frame_done  output  1  one-cycle pulse after the last pooled value transfers.
- idx_err  output  1  sticky flag: an out-of-range in_idx was received.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to FILL; the buffer contents are don't-care.
  - The 144-bit written bitmap and the written counter clear.
  - out_valid, frame_done and idx_err are 0; out_ch, out_idx and out_data are 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-frame discards all progress.
- FILL:
  - A write is accepted when in_valid && in_ready.
  - An accepted write stores in_data at buffer[in_ch*36+in_idx] and sets the matching bitmap bit.
  - The counter increments only if that bit was previously clear. A rewrite overwrites the data but does not count again.
  - in_idx > 35: no write, no count, idx_err is set (sticky until reset).
  - When a counted write brings the counter to 144, the next state is POOL and in_ready is 0 from the next cycle.
- POOL:
  - Iterates ch = 0..3 (outer), then orow = 0..2, then ocol = 0..2.
  - out_data = signed max of buffer positions (2*orow, 2*ocol), (2*orow, 2*ocol+1), (2*orow+1, 2*ocol) and (2*orow+1, 2*ocol+1) of channel ch.
  - The comparison is signed at full DWIDTH. On ties, the value is unchanged.
  - The output register loads one cycle after entry to POOL: first out_valid is 2 cycles after the completing write.
  - Handshake:
    - A transfer occurs on out_valid && out_ready.
    - While out_valid && !out_ready, out_ch, out_idx and out_data hold stable.
    - After each transfer, the next value is presented in the following cycle, so throughput is 1 value per cycle under continuous out_ready.
    - out_valid never drops without a transfer.
- DONE:
  - Entered on transfer of ch=3, idx=8.
  - frame_done=1 for exactly one cycle, and out_valid is 0.
  - Then FILL is re-entered: bitmap and counter clear, in_ready is 1 the following cycle.
  - idx_err persists.
- Input during POOL or DONE is ignored: in_ready is 0 and in_valid is not acted on.
- States: FILL -> POOL (count reaches 144) -> DONE (last transfer) -> FILL.

Optional Feature:
- Macro S3_OUT_SAT17_EN.
- When defined: out_data is the pooled maximum saturated to the signed 17-bit range [-65536, 65535], sign-extended to DWIDTH, so the result is usable as the next stage's 17-bit input tensor.
- When undefined: out_data is the unmodified DWIDTH maximum.
- Saturation applies after the max operation. All timing is identical in both builds.

Test Plan:
- Write all 144 entries with value ch*100+idx, out_ready held 1 -> 36 outputs in channel-major order; ch0 idx0 = 7, ch2 idx8 = 235; frame_done pulses 1 cycle after the last output.
- Write the channel 1 window {-5, -2, -9, -3} at positions 0, 1, 6, 7 (rest 0 is not the case; fill the rest with -100) -> ch1 idx0 = -2.
- Complete a frame, then hold out_ready=0 for 5 cycles after the first out_valid -> outputs stay stable with out_valid held; resuming yields all 36 values with none lost or duplicated.
- Write idx 5 of ch0 twice, first with 1 and then with 9, then write the other 143 entries -> POOL starts only after all 144 unique writes; ch0 idx2 reflects 9. Also write in_idx=40 -> idx_err=1, count unchanged.
- Assert rst_n=0 after 70 writes, then write a full frame -> normal output, no stale data; idx_err=0 after reset.
- With S3_OUT_SAT17_EN defined, fill a window with 200000 and another with -70000 -> outputs 65535 and -65536; without the macro, 200000 and -70000.
